fifo_uart_tx: RTL and testbench

- Consumer-side drain for the show-ahead sync FIFO: pops bytes with a one-cycle read strobe and serialises each as a UART 8N1 frame on tx.
- Sits between the FIFO (rd/empty/r_data port) and the board TX pin.
- Producers write bytes into the FIFO; this block empties it at line rate with no CPU involvement.

---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 33 +++
 rtl/fifo_uart_tx.sv | 101 ++++++++++
 tb/tb_fifo_uart_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter and its baud generator.
// Holds the FSM state encoding and the default bit period for the 12 MHz board clock.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // 12 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and flags the last and next-to-last cycles of each bit.
module uart_baud_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_end_o,
    output logic pre_end_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i || bit_end_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bit_end_o = (count_q == LAST);
    // Lets the transmitter register a pulse that lands in the final cycle of a bit.
    assign pre_end_o = (count_q == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO onto a UART 8N1 line: one pop strobe per byte,
// start bit, LSB-first data, stop bit, with all outputs registered.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int D_WIDTH      = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic [D_WIDTH-1:0] fifo_rdata,
    output logic               fifo_rd,
    output logic               tx,
    output logic               busy,
    output logic               tx_done
);

    localparam int IW = $clog2(D_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(D_WIDTH - 1);

    tx_state_e          state_q;
    logic [D_WIDTH-1:0] shift_q;
    logic [IW-1:0]      bit_idx_q;
    logic               bit_end;
    logic               pre_end;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == IDLE),
        .bit_end_o(bit_end),
        .pre_end_o(pre_end)
    );

    // NOTE: every register here uses <= so each branch sees pre-edge values only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            fifo_rd   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            tx_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (enable && !fifo_empty) begin
                        shift_q <= fifo_rdata;
                        fifo_rd <= 1'b1;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx        <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx        <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (pre_end) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural show-ahead FIFO, serial decoder and an
// expected-byte queue compared against every decoded frame.
module tb_fifo_uart_tx;

    localparam int D   = 8;
    localparam int CPB = 4;
    localparam int FRAME_CYC = (D + 2) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         fifo_empty;
    logic [D-1:0] fifo_rdata;
    logic         fifo_rd;
    logic         tx;
    logic         busy;
    logic         tx_done;

    fifo_uart_tx #(
        .D_WIDTH     (D),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Show-ahead FIFO model (at most 16 entries in flight)
    logic [D-1:0] fifo_mem [32];
    int rd_ptr  = 0;
    int wr_ptr  = 0;
    int pop_cnt = 0;
    int cyc     = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = fifo_mem[rd_ptr % 32];

    always @(posedge clk) begin
        cyc++;
        if (fifo_rd) begin
            rd_ptr++;
            pop_cnt++;
        end
    end

    logic [D-1:0] exp_q [$];
    int           starts_q [$];

    task automatic push_fifo(input logic [D-1:0] b, input bit expect_out);
        fifo_mem[wr_ptr % 32] = b;
        wr_ptr++;
        if (expect_out) exp_q.push_back(b);
    endtask

    // Serial decoder, sampled on the falling edge
    bit           in_frame    = 1'b0;
    int           dec_cnt     = 0;
    int           frames_done = 0;
    logic [D-1:0] rx_byte;

    always @(negedge clk) begin
        bit at_end;
        at_end = 1'b0;
        if (rst) begin
            in_frame = 1'b0;
            dec_cnt  = 0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                dec_cnt  = 0;
                starts_q.push_back(cyc);
                check("rd_pulse", {31'd0, fifo_rd}, 32'd1);
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == 1) check("rd_width", {31'd0, fifo_rd}, 32'd0);
            if (dec_cnt == CPB - 1) check("start_bit", {31'd0, tx}, 32'd0);
            if (dec_cnt >= CPB + 1 && dec_cnt <= D * CPB + 1 && (dec_cnt - 1) % CPB == 0)
                rx_byte[(dec_cnt - CPB - 1) / CPB] = tx;
            if (dec_cnt == FRAME_CYC / 2) check("busy_mid", {31'd0, busy}, 32'd1);
            if (dec_cnt == FRAME_CYC - CPB + 1) check("stop_bit", {31'd0, tx}, 32'd1);
            if (dec_cnt == FRAME_CYC - 1) begin
                at_end = 1'b1;
                check("tx_done_last", {31'd0, tx_done}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("frame_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
                frames_done++;
                in_frame = 1'b0;
            end
        end
        if (tx_done && !at_end) check("tx_done_stray", {31'd0, tx_done}, 32'd0);
        if (fifo_rd && !(in_frame && dec_cnt == 0)) check("rd_stray", {31'd0, fifo_rd}, 32'd0);
    end

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !in_frame && !busy && (fifo_empty || !enable)) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_dec(input int frame_target, input int cnt_target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            if (frames_done == frame_target && in_frame && dec_cnt == cnt_target) hit = 1'b1;
        end
        if (!hit) check("dec_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int pops0;
        int fr0;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        #1 rst = 1'b0;

        // Idle with an empty FIFO
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx", {31'd0, tx}, 32'd1);
            check("idle_rd", {31'd0, fifo_rd}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Single byte
        pops0 = pop_cnt;
        push_fifo(8'hA5, 1'b1);
        wait_drain(200);
        check("single_pops", pop_cnt - pops0, 32'd1);
        check("single_empty", {31'd0, fifo_empty}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames
        enable = 1'b0;
        starts_q.delete();
        pops0 = pop_cnt;
        push_fifo(8'h00, 1'b1);
        push_fifo(8'hFF, 1'b1);
        push_fifo(8'h3C, 1'b1);
        @(negedge clk); #1 enable = 1'b1;
        wait_drain(400);
        check("b2b_pops", pop_cnt - pops0, 32'd3);
        check("b2b_starts", starts_q.size(), 32'd3);
        if (starts_q.size() == 3) begin
            check("b2b_gap0", starts_q[1] - starts_q[0], FRAME_CYC + 1);
            check("b2b_gap1", starts_q[2] - starts_q[1], FRAME_CYC + 1);
        end
        check("b2b_empty", {31'd0, fifo_empty}, 32'd1);

        // Enable gating
        enable = 1'b0;
        pops0 = pop_cnt;
        push_fifo(8'h11, 1'b1);
        push_fifo(8'h22, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("gate_rd", {31'd0, fifo_rd}, 32'd0);
            check("gate_tx", {31'd0, tx}, 32'd1);
        end
        fr0 = frames_done;
        #1 enable = 1'b1;
        wait_dec(fr0, 10, 100);
        enable = 1'b0;
        wait_drain(200);
        repeat (50) @(negedge clk);
        check("gate_pops", pop_cnt - pops0, 32'd1);
        check("gate_left", {31'd0, fifo_empty}, 32'd0);
        check("gate_head", {24'd0, fifo_rdata}, 32'h22);

        // Reset during bit 3 of the second queued byte
        exp_q.push_back(8'h22);
        push_fifo(8'h5A, 1'b1);
        push_fifo(8'h81, 1'b1);
        fr0 = frames_done;
        #1 enable = 1'b1;
        wait_dec(fr0 + 1, CPB * 4 + 1, 200);
        void'(exp_q.pop_front());
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rd", {31'd0, fifo_rd}, 32'd0);
        check("abort_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        wait_drain(200);
        check("abort_frames", frames_done - fr0, 32'd2);
        check("abort_empty", {31'd0, fifo_empty}, 32'd1);

        // Full drain of 16 bytes
        enable = 1'b0;
        pops0 = pop_cnt;
        fr0 = frames_done;
        for (int i = 0; i < 16; i++) push_fifo(8'(i), 1'b1);
        @(negedge clk); #1 enable = 1'b1;
        wait_drain(16 * (FRAME_CYC + 1) + 200);
        check("drain_pops", pop_cnt - pops0, 32'd16);
        check("drain_frames", frames_done - fr0, 32'd16);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("drain_idle_tx", {31'd0, tx}, 32'd1);
        end
        check("drain_leftover", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
